// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Operand-forwarding and load-use hazard control for a 5-stage pipeline.
//   Shadows the destination info of the instructions in EX, MEM and WB,
//   produces the registered EX-operand mux selects and a combinational stall.
//
//   Build option: HAZARD_FWD_EN
//     defined   : full forwarding; only load-use dependences stall.
//     undefined : selects held at 00; any EX/MEM producer of a used source
//                 stalls until it reaches WB.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active low
//   id_rs_i/rt_i   source register fields of the ID instruction
//   id_rs_use_i    ID instruction reads rs
//   id_rt_use_i    ID instruction reads rt
//   id_rd_i        destination of the ID instruction
//   id_regwrite_i  ID instruction writes the register file
//   id_memread_i   ID instruction is a load
//   flush_i        ID instruction is squashed and enters EX as a bubble
//   stall_o        hold PC and IF/ID, bubble into ID/EX (combinational)
//   fwd_a_o/b_o    EX operand selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall_cnt_o    saturating count of stall cycles
module hazard_fwd_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_rs_use_i,
  input  logic             id_rt_use_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  slot_t ex_slot, mem_slot, wb_slot;

  logic ex_prod_rs, ex_prod_rt, mem_prod_rs, mem_prod_rt;
  logic [1:0] sel_a, sel_b;
  logic bubble;

  // Write-first register file: a WB producer needs no action, so the WB
  // slot and the downstream memread bits are tracked but not consumed.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb_slot, mem_slot.memread, ex_slot.memread};

  // Register 0 never produces.
  assign ex_prod_rs  = ex_slot.valid  & ex_slot.regwrite  & (ex_slot.rd  == id_rs_i) & (id_rs_i != 5'd0);
  assign ex_prod_rt  = ex_slot.valid  & ex_slot.regwrite  & (ex_slot.rd  == id_rt_i) & (id_rt_i != 5'd0);
  assign mem_prod_rs = mem_slot.valid & mem_slot.regwrite & (mem_slot.rd == id_rs_i) & (id_rs_i != 5'd0);
  assign mem_prod_rt = mem_slot.valid & mem_slot.regwrite & (mem_slot.rd == id_rt_i) & (id_rt_i != 5'd0);

  // Nearer producer wins.
  assign sel_a = (id_rs_use_i & ex_prod_rs)  ? 2'b10 :
                 (id_rs_use_i & mem_prod_rs) ? 2'b01 : 2'b00;
  assign sel_b = (id_rt_use_i & ex_prod_rt)  ? 2'b10 :
                 (id_rt_use_i & mem_prod_rt) ? 2'b01 : 2'b00;

`ifdef HAZARD_FWD_EN
  assign stall_o = ~flush_i & ex_slot.memread &
                   ((id_rs_use_i & ex_prod_rs) | (id_rt_use_i & ex_prod_rt));
`else
  assign stall_o = ~flush_i &
                   ((id_rs_use_i & (ex_prod_rs | mem_prod_rs)) |
                    (id_rt_use_i & (ex_prod_rt | mem_prod_rt)));
`endif

  assign bubble = stall_o | flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_slot     <= '0;
      mem_slot    <= '0;
      wb_slot     <= '0;
      fwd_a_o     <= 2'b00;
      fwd_b_o     <= 2'b00;
      stall_cnt_o <= '0;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (bubble) begin
        ex_slot <= '0;
        fwd_a_o <= 2'b00;
        fwd_b_o <= 2'b00;
      end else begin
        ex_slot <= '{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i,
                     memread: id_memread_i};
`ifdef HAZARD_FWD_EN
        fwd_a_o <= sel_a;
        fwd_b_o <= sel_b;
`else
        fwd_a_o <= 2'b00;
        fwd_b_o <= 2'b00;
`endif
      end
      if (stall_o && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

`ifndef HAZARD_FWD_EN
  logic unused_sel;
  assign unused_sel = ^{sel_a, sel_b};
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs_i, id_rt_i, id_rd_i;
  logic       id_rs_use_i, id_rt_use_i, id_regwrite_i, id_memread_i, flush_i;
  logic       stall_o;
  logic [1:0] fwd_a_o, fwd_b_o;
  logic [3:0] stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_fwd_unit #(.CNT_W(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_rs_use_i   (id_rs_use_i),
    .id_rt_use_i   (id_rt_use_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present an ID instruction; inputs settle before any check.
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu,
                       input logic [4:0] rd, input logic rw,
                       input logic mr, input logic fl);
    id_rs_i = rs; id_rt_i = rt; id_rs_use_i = rsu; id_rt_use_i = rtu;
    id_rd_i = rd; id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop();
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    rst_i = 1'b0;
    nop();
    tick(); tick();
    chk("rst_stall", stall_o, 0);
    chk("rst_fwd_a", fwd_a_o, 0);
    chk("rst_fwd_b", fwd_b_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    rst_i = 1'b1;

`ifdef HAZARD_FWD_EN
    // add $3 ; sub reads $3 -> EX/MEM forward
    issue(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();
    issue(5'd3, 5'd7, 1, 1, 5'd8, 1, 0, 0);
    chk("exfwd_stall", stall_o, 0);
    tick();
    chk("exfwd_a", fwd_a_o, 2);
    chk("exfwd_b", fwd_b_o, 0);

    // add $3 ; nop ; or reads rt=$3 -> MEM/WB forward
    drain();
    issue(5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0); tick();
    nop(); tick();
    issue(5'd9, 5'd3, 1, 1, 5'd10, 1, 0, 0);
    chk("memfwd_stall", stall_o, 0);
    tick();
    chk("memfwd_b", fwd_b_o, 1);
    chk("memfwd_a", fwd_a_o, 0);

    // two producers of $3: nearer one wins
    drain();
    issue(5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0); tick();
    issue(5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0); tick();
    issue(5'd3, 5'd3, 1, 1, 5'd12, 1, 0, 0); tick();
    chk("prio_a", fwd_a_o, 2);
    chk("prio_b", fwd_b_o, 2);

    // use flags clear -> no forward
    drain();
    issue(5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0); tick();
    issue(5'd3, 5'd3, 0, 0, 5'd12, 1, 0, 0); tick();
    chk("nouse_a", fwd_a_o, 0);
    chk("nouse_b", fwd_b_o, 0);

    // lw $4 ; reader of $4 -> one stall, then 01
    drain();
    issue(5'd0, 5'd0, 0, 0, 5'd4, 1, 1, 0); tick();
    issue(5'd4, 5'd0, 1, 0, 5'd11, 1, 0, 0);
    chk("lu_stall", stall_o, 1);
    chk("lu_cnt0", stall_cnt_o, 0);
    tick();
    chk("lu_bubble_a", fwd_a_o, 0);
    chk("lu_stall_end", stall_o, 0);
    chk("lu_cnt1", stall_cnt_o, 1);
    tick();
    chk("lu_fwd_a", fwd_a_o, 1);

    // load to $0, reader of $0 -> nothing
    drain();
    issue(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0); tick();
    issue(5'd0, 5'd0, 1, 1, 5'd11, 1, 0, 0);
    chk("r0_stall", stall_o, 0);
    tick();
    chk("r0_a", fwd_a_o, 0);
    chk("r0_b", fwd_b_o, 0);

    // flush beats load-use stall
    drain();
    issue(5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0); tick();
    issue(5'd5, 5'd0, 1, 0, 5'd11, 1, 0, 1);
    chk("flush_stall", stall_o, 0);
    tick();
    chk("flush_bubble_a", fwd_a_o, 0);
    chk("flush_cnt", stall_cnt_o, 1);

    // reset during a stall
    drain();
    issue(5'd0, 5'd0, 0, 0, 5'd6, 1, 1, 0); tick();
    issue(5'd6, 5'd0, 1, 0, 5'd11, 1, 0, 0);
    chk("rstmid_pre", stall_o, 1);
    rst_i = 1'b0;
    tick();
    chk("rstmid_stall", stall_o, 0);
    chk("rstmid_a", fwd_a_o, 0);
    chk("rstmid_cnt", stall_cnt_o, 0);
    rst_i = 1'b1;

    // 19 one-cycle load-use stalls, counter saturates at 15
    for (int i = 0; i < 19; i++) begin
      issue(5'd0, 5'd0, 0, 0, 5'd4, 1, 1, 0); tick();
      issue(5'd4, 5'd0, 1, 0, 5'd11, 1, 0, 0); tick();
      if (i == 13) chk("sat_cnt14", stall_cnt_o, 14);
    end
    chk("sat_cnt", stall_cnt_o, 15);
`else
    // add $5 ; reader of $5 -> two stall cycles, selects stay 00
    issue(5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0); tick();
    issue(5'd5, 5'd0, 1, 0, 5'd11, 1, 0, 0);
    chk("nf_stall1", stall_o, 1);
    tick();
    chk("nf_stall2", stall_o, 1);
    chk("nf_a_bubble", fwd_a_o, 0);
    tick();
    chk("nf_stall_end", stall_o, 0);
    chk("nf_cnt2", stall_cnt_o, 2);
    tick();
    chk("nf_a", fwd_a_o, 0);
    chk("nf_b", fwd_b_o, 0);

    // add $3 ; nop ; rt reader -> MEM producer still stalls once
    drain();
    issue(5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0); tick();
    nop(); tick();
    issue(5'd9, 5'd3, 1, 1, 5'd10, 1, 0, 0);
    chk("nf_mem_stall", stall_o, 1);
    tick();
    chk("nf_mem_end", stall_o, 0);
    chk("nf_cnt3", stall_cnt_o, 3);

    // unused source does not stall
    drain();
    issue(5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0); tick();
    issue(5'd3, 5'd3, 0, 0, 5'd10, 1, 0, 0);
    chk("nf_nouse", stall_o, 0);

    // $0 producer never stalls
    drain();
    issue(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0); tick();
    issue(5'd0, 5'd0, 1, 1, 5'd11, 1, 0, 0);
    chk("nf_r0", stall_o, 0);

    // flush beats stall; bubble leaves producer in MEM
    drain();
    issue(5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 0); tick();
    issue(5'd7, 5'd0, 1, 0, 5'd11, 1, 0, 1);
    chk("nf_flush", stall_o, 0);
    tick();
    issue(5'd7, 5'd0, 1, 0, 5'd11, 1, 0, 0);
    chk("nf_post_flush", stall_o, 1);

    // reset during a stall
    rst_i = 1'b0;
    tick();
    chk("rstmid_stall", stall_o, 0);
    chk("rstmid_a", fwd_a_o, 0);
    chk("rstmid_cnt", stall_cnt_o, 0);
    rst_i = 1'b1;

    // each iteration: two stall cycles; saturates at 15
    for (int i = 0; i < 10; i++) begin
      issue(5'd0, 5'd0, 0, 0, 5'd4, 1, 0, 0); tick();
      issue(5'd4, 5'd0, 1, 0, 5'd11, 1, 0, 0); tick(); tick(); tick();
      if (i == 6) chk("sat_cnt14", stall_cnt_o, 14);
    end
    chk("sat_cnt", stall_cnt_o, 15);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Forwarding and hazard-control unit for the 5-stage pipelined CPU. It tracks destination-register information for the instructions in EX, MEM and WB. It generates the 2-bit select codes that drive the EX-stage operand forwarding multiplexers, and it raises a stall for load-use hazards. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and feeds the `select_i` of both ALU-operand 3:1 muxes.

## Interface
- `CNT_W`, default 16: width of the stall performance counter.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `id_rs_i`  in  5  rs field of the instruction in ID.
- `id_rt_i`  in  5  rt field of the instruction in ID.
- `id_rs_use_i`, `id_rt_use_i`  in  1 each  the ID instruction actually reads rs / rt.
- `id_rd_i`  in  5  destination register of the ID instruction (after RegDst mux).
- `id_regwrite_i`  in  1  the ID instruction writes the register file.
- `id_memread_i`  in  1  the ID instruction is a load.
- `flush_i`  in  1  the ID instruction is squashed (taken branch/jump) and enters EX as a bubble.
- `stall_o`  out  1  hold PC and IF/ID; insert a bubble into ID/EX. Combinational.
- `fwd_a_o`, `fwd_b_o`  out  2 each  registered mux selects for the EX operands: 00 = register-file data, 01 = MEM/WB write-back data, 10 = EX/MEM ALU result. 11 is never driven.
- `stall_cnt_o`  out  `CNT_W`  number of cycles with `stall_o`=1; saturates at all-ones.

## Operation
- Internal shadow slots, each holding {valid, rd, regwrite, memread}:
  - EX slot: mirrors ID/EX.
  - MEM slot: mirrors EX/MEM.
  - WB slot: mirrors MEM/WB.
- Every cycle the slots shift: WB ← MEM, MEM ← EX, EX ← ID info. EX is loaded with a bubble (valid=0) when `stall_o` or `flush_i` is 1.
- A slot "produces r" when valid & regwrite & rd==r & r!=0. Register 0 is never forwarded and never stalls.
- Load-use stall: `stall_o` = EX slot valid & memread & regwrite & rd!=0 & ((`id_rs_use_i` & rd==`id_rs_i`) | (`id_rt_use_i` & rd==`id_rt_i`)). `flush_i`=1 forces `stall_o`=0 (the flush wins).
- Forward select for the ID rs operand, computed in ID and registered into `fwd_a_o` as the instruction moves to EX:
  - 10 if the current EX slot produces rs (it will be in MEM).
  - else 01 if the current MEM slot produces rs (it will be in WB).
  - else 00.
  - The nearer producer has priority. `fwd_b_o` is computed the same way for rt.
  - If the use flag is 0, the select is 00.
- When a bubble enters EX, `fwd_a_o`/`fwd_b_o` are loaded with 00.
- The register file is write-first, so a WB-stage producer read in ID needs no action.
- `stall_cnt_o` increments on each cycle with `stall_o`=1 and holds at 2^`CNT_W`−1.

## Timing
- Reset (`rst_i`=0 at a clock edge):
  - all slots invalid;
  - `fwd_a_o` = `fwd_b_o` = 00;
  - `stall_cnt_o` = 0;
  - `stall_o` therefore 0.
- Reset asserted mid-stall clears the EX slot, so `stall_o` drops in the cycle after the edge.
- Select latency: one cycle. The selects for the instruction in EX during cycle n were computed from ID inputs in cycle n−1.
- A load-use stall lasts exactly one cycle: the load then sits in MEM, and the dependent instruction, re-presented in ID, receives 01 on its next entry to EX.
- Stall and flush in the same cycle: flush wins; `stall_o`=0 and EX gets a bubble.

## Configuration
- `HAZARD_FWD_EN` defined: full forwarding as above.
- `HAZARD_FWD_EN` undefined:
  - `fwd_a_o`/`fwd_b_o` are held at 00;
  - `stall_o` = 1 whenever the EX or MEM slot produces a used ID source (any instruction, not only loads);
  - the flush-overrides-stall rule still applies;
  - the dependent instruction waits until its producer reaches WB.

## Test plan
- add $3 in EX, then sub reading $3 in ID → next cycle `fwd_a_o`=10, `stall_o`=0.
- add $3, nop, then or reading rt=$3 → `fwd_b_o`=01. With both slots producing $3, the select is 10 (priority).
- lw $4 in EX, ID reads rs=$4 → `stall_o`=1 for one cycle, EX bubble, then `fwd_a_o`=01. `stall_cnt_o` goes 0→1.
- Producer with rd=$0 and regwrite=1, consumer reads $0 → selects 00, no stall. With `flush_i`=1 during a load-use match → `stall_o`=0.
- `HAZARD_FWD_EN` undefined, add $5 then a reader of $5 → `stall_o`=1 for 2 cycles, selects stay 00. Assert `rst_i`=0 during a stall → all outputs 0 after the edge.
- 2^`CNT_W`+3 back-to-back load-use stalls (`CNT_W`=4 build) → `stall_cnt_o` saturates at 15.
